alu_cmd_issuer: RTL and testbench
=================================

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles alu_start may stay high without alu_done.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_a in 8, cmd_b in 8, cmd_op in 3 (operation_t): upstream command channel.
REQ-006 SHALL have ports alu_start out 1, alu_op out 3, alu_a out 8, alu_b out 8, alu_reset_n out 1: drive to ALU.
REQ-007 SHALL have ports alu_done in 1, alu_result in 16: ALU completion.
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_result out 16, rsp_op out 3, rsp_err out 1: response channel.
REQ-009 SHALL have port busy out 1: high when FIFO non-empty or FSM not IDLE.

Function
REQ-010 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready = not FIFO full (combinational from count, no pass-through).
REQ-011 SHALL keep count unchanged on simultaneous push and pop; push when full is impossible because cmd_ready is low.
REQ-012 SHALL implement FSM states IDLE, DRIVE, RESP, ALU_RST.
REQ-013 IDLE, FIFO non-empty: pop head; add_op/and_op/xor_op/mul_op -> load alu_op/a/b, alu_start=1, go DRIVE; rst_op -> go ALU_RST; no_op and undefined codes (101, 110) -> discard, stay IDLE, no response.
REQ-014 Latency: command accepted into an empty FIFO at edge E0 with FSM in IDLE SHALL have alu_start high from edge E1.
REQ-015 DRIVE: alu_start, alu_op, alu_a, alu_b SHALL be held stable until alu_done is sampled high.
REQ-016 On alu_done high in DRIVE: capture alu_result into rsp_result and op into rsp_op, rsp_err=0, alu_start=0, rsp_valid=1, go RESP.
REQ-017 In DRIVE, a 16-bit cycle counter SHALL count cycles with alu_start high; when it reaches TIMEOUT+1 without alu_done: rsp_result=16'h0000, rsp_err=1, alu_start=0, go RESP.
REQ-018 RESP: rsp_valid, rsp_result, rsp_op, rsp_err SHALL be held stable until rsp_ready is sampled high; then rsp_valid=0, go IDLE.
REQ-019 alu_start SHALL be low for at least one cycle between consecutive commands.
REQ-020 ALU_RST: alu_reset_n SHALL be low for exactly 2 cycles, then high, then go IDLE; no response produced.
REQ-021 alu_done sampled outside DRIVE SHALL be ignored.
REQ-022 cmd channel SHALL keep accepting into FIFO while FSM is in DRIVE, RESP or ALU_RST.

Reset
REQ-023 On reset_n low, immediately: FIFO empty, FSM IDLE, timeout counter 0.
REQ-024 Reset values: alu_start 0, alu_op no_op, alu_a/alu_b 0, alu_reset_n 1, rsp_valid 0, rsp_result 0, rsp_op no_op, rsp_err 0, busy 0, cmd_ready 1.
REQ-025 Reset mid-operation SHALL discard in-flight and queued commands with no response.

Structure
REQ-026 operation_t (no_op 000, add_op 001, and_op 010, xor_op 011, mul_op 100, rst_op 111) and the FSM state enum SHALL live in tinyalu_pkg.
REQ-027 The command FIFO SHALL be a sub-module alu_cmd_fifo (parameter DEPTH, width 19, push/pop/full/empty/count).

Verification
REQ-028 add_op A=8'h12 B=8'h34, alu_done one cycle after start with 16'h0046 -> rsp_result 16'h0046, rsp_op add_op, rsp_err 0; start high from E1 until done edge.
REQ-029 DEPTH=4, alu_done held low, TIMEOUT=100, 6 back-to-back commands -> first popped, 4 queued, cmd_ready low after 5th accept, 6th stalled.
REQ-030 mul_op A=8'hFF B=8'hFF, done after 3 cycles with 16'hFE01, rsp_ready low 5 cycles -> response stable, no new alu_start until handshake.
REQ-031 no_op then rst_op then xor_op 8'hF0/8'h0F -> no start for no_op, alu_reset_n low exactly 2 cycles, then xor response 16'h00FF.
REQ-032 TIMEOUT=15, alu_done never -> alu_start drops after 16 high cycles, rsp_err 1, rsp_result 0.
REQ-033 reset_n low during DRIVE with 3 queued -> all outputs at reset values same cycle, busy 0, no later response.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared types for the ALU command issuer: opcodes, FSM states and the queued command layout.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP,
        ALU_RST
    } state_t;

    typedef struct packed {
        operation_t op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic logic is_alu_op(operation_t op);
        return op inside {add_op, and_op, xor_op, mul_op};
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU drive and response channels of the issuer in one bundle.
interface alu_cmd_issuer_if;
    import tinyalu_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    operation_t  cmd_op;

    logic        alu_start;
    operation_t  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_reset_n;
    logic        alu_done;
    logic [15:0] alu_result;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    operation_t  rsp_op;
    logic        rsp_err;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
        output cmd_ready, alu_start, alu_op, alu_a, alu_b, alu_reset_n,
               rsp_valid, rsp_result, rsp_op, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
        input  cmd_ready, alu_start, alu_op, alu_a, alu_b, alu_reset_n,
               rsp_valid, rsp_result, rsp_op, rsp_err
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO, power-of-2 DEPTH; read data is the head entry, valid while not empty.
// Latency 1 cycle push-to-visible; caller must not push when full nor pop when empty.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    pop,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands and issues them one at a time, returning result or timeout error.
// Latency: accept at E0 into an empty queue -> alu_start from E1; response held until rsp_ready.
module alu_cmd_issuer
    import tinyalu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_cmd_issuer_if.master   bus,
    output logic               busy
);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT);

    state_t                 state, state_nxt;
    logic [15:0]            cnt, cnt_nxt;

    logic                   push, pop, full, empty;
    logic [$clog2(DEPTH):0] count;
    cmd_t                   wr_cmd;
    logic [CMD_W-1:0]       rd_bits;
    cmd_t                   head;

    logic                   start_q, start_nxt;
    operation_t             op_q, op_nxt;
    logic [7:0]             a_q, a_nxt, b_q, b_nxt;
    logic                   arstn_q, arstn_nxt;
    logic                   rv_q, rv_nxt;
    logic [15:0]            rres_q, rres_nxt;
    operation_t             rop_q, rop_nxt;
    logic                   rerr_q, rerr_nxt;

    assign wr_cmd        = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
    assign push          = bus.cmd_valid && !full;
    assign head          = cmd_t'(rd_bits);
    assign bus.cmd_ready = !full;
    assign busy          = (count != '0) || (state != IDLE);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (wr_cmd),
        .pop     (pop),
        .rdata   (rd_bits),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
            op_q    <= no_op;
            a_q     <= '0;
            b_q     <= '0;
            arstn_q <= 1'b1;
            rv_q    <= 1'b0;
            rres_q  <= '0;
            rop_q   <= no_op;
            rerr_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            start_q <= start_nxt;
            op_q    <= op_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            arstn_q <= arstn_nxt;
            rv_q    <= rv_nxt;
            rres_q  <= rres_nxt;
            rop_q   <= rop_nxt;
            rerr_q  <= rerr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start_nxt = start_q;
        op_nxt    = op_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        arstn_nxt = arstn_q;
        rv_nxt    = rv_q;
        rres_nxt  = rres_q;
        rop_nxt   = rop_q;
        rerr_nxt  = rerr_q;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) begin
                    // no_op and unknown codes are popped and dropped silently
                    pop = 1'b1;
                    if (is_alu_op(head.op)) begin
                        op_nxt    = head.op;
                        a_nxt     = head.a;
                        b_nxt     = head.b;
                        start_nxt = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = DRIVE;
                    end else if (head.op == rst_op) begin
                        arstn_nxt = 1'b0;
                        cnt_nxt   = '0;
                        state_nxt = ALU_RST;
                    end
                end
            end
            DRIVE: begin
                if (bus.alu_done) begin
                    rres_nxt  = bus.alu_result;
                    rop_nxt   = op_q;
                    rerr_nxt  = 1'b0;
                    rv_nxt    = 1'b1;
                    start_nxt = 1'b0;
                    state_nxt = RESP;
                end else if (cnt == TO_LAST) begin
                    // TIMEOUT+1 cycles of alu_start without completion
                    rres_nxt  = '0;
                    rop_nxt   = op_q;
                    rerr_nxt  = 1'b1;
                    rv_nxt    = 1'b1;
                    start_nxt = 1'b0;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rv_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            ALU_RST: begin
                if (cnt == 16'd1) begin
                    arstn_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.alu_start   = start_q;
    assign bus.alu_op      = op_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_reset_n = arstn_q;
    assign bus.rsp_valid   = rv_q;
    assign bus.rsp_result  = rres_q;
    assign bus.rsp_op      = rop_q;
    assign bus.rsp_err     = rerr_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a transaction-level reference model checked every cycle.
module tb_alu_cmd_issuer;
    import tinyalu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic busy;

    alu_cmd_issuer_if bus();

    alu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b001:  return 16'(a) + 16'(b);
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // ALU stand-in: done after done_delay start-high cycles (negative: never)
    int done_delay = -1;
    int spur_cnt   = 0;
    initial begin : alu_model
        int hi_cnt;
        int spur_seen;
        hi_cnt    = 0;
        spur_seen = 0;
        bus.alu_done   = 1'b0;
        bus.alu_result = 16'h0000;
        forever begin
            @(negedge clk);
            bus.alu_done = 1'b0;
            if (bus.alu_start) begin
                if (done_delay >= 0 && hi_cnt == done_delay) begin
                    bus.alu_done   = 1'b1;
                    bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
                end
                hi_cnt++;
            end else begin
                hi_cnt = 0;
                if (spur_cnt != spur_seen) begin
                    bus.alu_done   = 1'b1;
                    bus.alu_result = 16'hDEAD;
                    spur_seen++;
                end
            end
        end
    end

    // Length of the most recent completed alu_start burst
    int last_run = 0;
    initial begin : run_mon
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (bus.alu_start) run++;
            else if (run > 0) begin
                last_run = run;
                run = 0;
            end
        end
    end

    // Reference model: queue of waiting commands plus what the outputs must currently show
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } mcmd_t;

    mcmd_t       mq[$];
    bit          e_start  = 0;
    logic [2:0]  e_op     = 3'b000;
    logic [7:0]  e_a      = 8'h00;
    logic [7:0]  e_b      = 8'h00;
    bit          e_arstn  = 1;
    bit          e_rv     = 0;
    logic [15:0] e_res    = 16'h0000;
    logic [2:0]  e_rop    = 3'b000;
    bit          e_err    = 0;
    int          e_hi     = 0;
    int          rst_left = 0;

    initial begin : model
        mcmd_t c;
        mcmd_t h;
        bit    take;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                e_start = 0; e_op = 3'b000; e_a = 8'h00; e_b = 8'h00;
                e_arstn = 1; e_rv = 0; e_res = 16'h0000; e_rop = 3'b000; e_err = 0;
                e_hi = 0; rst_left = 0;
            end else begin
                take = bus.cmd_valid && (mq.size() < DEPTH);
                c    = '{bus.cmd_op, bus.cmd_a, bus.cmd_b};
                if (e_rv) begin
                    if (bus.rsp_ready) e_rv = 0;
                end else if (e_start) begin
                    e_hi++;
                    if (bus.alu_done) begin
                        e_res = bus.alu_result; e_rop = e_op; e_err = 0; e_rv = 1; e_start = 0;
                    end else if (e_hi == TIMEOUT + 1) begin
                        e_res = 16'h0000; e_rop = e_op; e_err = 1; e_rv = 1; e_start = 0;
                    end
                end else if (rst_left > 0) begin
                    rst_left--;
                    if (rst_left == 0) e_arstn = 1;
                end else if (mq.size() > 0) begin
                    h = mq.pop_front();
                    if (h.op inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
                        e_start = 1; e_op = h.op; e_a = h.a; e_b = h.b; e_hi = 0;
                    end else if (h.op == 3'b111) begin
                        e_arstn = 0; rst_left = 2;
                    end
                end
                if (take) mq.push_back(c);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("cmd_ready", 32'(bus.cmd_ready), 32'(mq.size() < DEPTH));
                chk("busy", 32'(busy), 32'(mq.size() > 0 || e_start || e_rv || rst_left > 0));
                chk("alu_start", 32'(bus.alu_start), 32'(e_start));
                chk("alu_reset_n", 32'(bus.alu_reset_n), 32'(e_arstn));
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
                if (e_start) begin
                    chk("alu_op", 32'(bus.alu_op), 32'(e_op));
                    chk("alu_a", 32'(bus.alu_a), 32'(e_a));
                    chk("alu_b", 32'(bus.alu_b), 32'(e_b));
                end
                if (e_rv) begin
                    chk("rsp_result", 32'(bus.rsp_result), 32'(e_res));
                    chk("rsp_op", 32'(bus.rsp_op), 32'(e_rop));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = operation_t'(op);
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_arrives", 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_alu_start"},   32'(bus.alu_start),   32'd0);
        chk({tag, "_alu_op"},      32'(bus.alu_op),      32'd0);
        chk({tag, "_alu_a"},       32'(bus.alu_a),       32'd0);
        chk({tag, "_alu_b"},       32'(bus.alu_b),       32'd0);
        chk({tag, "_alu_reset_n"}, 32'(bus.alu_reset_n), 32'd1);
        chk({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'd0);
        chk({tag, "_rsp_result"},  32'(bus.rsp_result),  32'd0);
        chk({tag, "_rsp_op"},      32'(bus.rsp_op),      32'd0);
        chk({tag, "_rsp_err"},     32'(bus.rsp_err),     32'd0);
        chk({tag, "_busy"},        32'(busy),            32'd0);
        chk({tag, "_cmd_ready"},   32'(bus.cmd_ready),   32'd1);
    endtask

    initial begin : main
        int rst_low, starts, overlap, first_start_i, last_rst_i, stall, quiet;
        logic [15:0] got_res;
        logic [2:0]  got_op;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = no_op;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // add 12+34, done one cycle after start
        done_delay = 0;
        send(3'b001, 8'h12, 8'h34);
        chk("lat_e0_start_low", 32'(bus.alu_start), 32'd0);
        @(negedge clk);
        chk("lat_e1_start_high", 32'(bus.alu_start), 32'd1);
        chk("add_alu_a", 32'(bus.alu_a), 32'h12);
        wait_rsp();
        chk("add_result", 32'(bus.rsp_result), 32'h0046);
        chk("add_op", 32'(bus.rsp_op), 32'd1);
        chk("add_err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        chk("add_start_cycles", 32'(last_run), 32'd1);
        wait_idle();

        // mul FF*FF with held-off response and a second command waiting
        bus.rsp_ready = 1'b0;
        done_delay    = 2;
        send(3'b100, 8'hFF, 8'hFF);
        send(3'b010, 8'hA5, 8'h3C);
        wait_rsp();
        chk("mul_result", 32'(bus.rsp_result), 32'hFE01);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mul_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("mul_hold_result", 32'(bus.rsp_result), 32'hFE01);
            chk("mul_hold_op", 32'(bus.rsp_op), 32'd4);
            chk("mul_no_new_start", 32'(bus.alu_start), 32'd0);
        end
        chk("mul_start_cycles", 32'(last_run), 32'd3);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        wait_rsp();
        chk("and_result", 32'(bus.rsp_result), 32'h0024);
        wait_idle();

        // spurious done while idle, then discarded codes, then no_op/rst_op/xor
        done_delay = 0;
        spur_cnt++;
        repeat (3) @(negedge clk);
        chk("spur_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("spur_idle", 32'(busy), 32'd0);
        send(3'b000, 8'h01, 8'h01);
        send(3'b101, 8'h02, 8'h02);
        send(3'b110, 8'h03, 8'h03);
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.alu_start || bus.rsp_valid) starts++;
            @(negedge clk);
        end
        chk("discard_no_activity", 32'(starts), 32'd0);
        chk("discard_idle", 32'(busy), 32'd0);

        send(3'b000, 8'h00, 8'h00);
        send(3'b111, 8'h00, 8'h00);
        send(3'b011, 8'hF0, 8'h0F);
        rst_low = 0; starts = 0; overlap = 0; first_start_i = -1; last_rst_i = -1;
        got_res = 16'hXXXX; got_op = 3'bxxx;
        for (int i = 0; i < 30; i++) begin
            if (!bus.alu_reset_n) begin
                rst_low++;
                last_rst_i = i;
            end
            if (bus.alu_start) begin
                starts++;
                if (first_start_i < 0) first_start_i = i;
                if (!bus.alu_reset_n) overlap++;
            end
            if (bus.rsp_valid) begin
                got_res = bus.rsp_result;
                got_op  = bus.rsp_op;
            end
            @(negedge clk);
        end
        chk("rst_low_cycles", 32'(rst_low), 32'd2);
        chk("rst_start_cycles", 32'(starts), 32'd1);
        chk("rst_no_overlap", 32'(overlap), 32'd0);
        chk("rst_then_start", 32'(first_start_i > last_rst_i), 32'd1);
        chk("xor_result", 32'(got_res), 32'h00FF);
        chk("xor_op", 32'(got_op), 32'd3);

        // fill the queue behind a stuck command
        done_delay    = -1;
        bus.rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(3'b001, 8'(i), 8'(i));
        chk("full_after_5", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = add_op;
        bus.cmd_a     = 8'h06;
        bus.cmd_b     = 8'h06;
        stall = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!bus.cmd_ready) stall++;
        end
        chk("sixth_stalled", 32'(stall), 32'd5);
        bus.cmd_valid = 1'b0;
        wait_rsp();
        chk("stuck_err", 32'(bus.rsp_err), 32'd1);
        chk("stuck_result", 32'(bus.rsp_result), 32'h0000);
        done_delay    = 0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        wait_idle();

        // timeout with TIMEOUT=15
        done_delay    = -1;
        bus.rsp_ready = 1'b0;
        send(3'b011, 8'h01, 8'h02);
        wait_rsp();
        chk("to_err", 32'(bus.rsp_err), 32'd1);
        chk("to_result", 32'(bus.rsp_result), 32'h0000);
        chk("to_op", 32'(bus.rsp_op), 32'd3);
        @(negedge clk);
        chk("to_start_cycles", 32'(last_run), 32'd16);
        bus.rsp_ready = 1'b1;
        wait_idle();

        // reset during DRIVE with three queued
        done_delay = -1;
        send(3'b001, 8'h07, 8'h08);
        send(3'b010, 8'h07, 8'h08);
        send(3'b011, 8'h07, 8'h08);
        send(3'b100, 8'h07, 8'h08);
        chk("pre_rst_start", 32'(bus.alu_start), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.alu_start || bus.rsp_valid || busy) quiet++;
        end
        chk("post_rst_silent", 32'(quiet), 32'd0);

        // normal operation after reset
        done_delay = 0;
        send(3'b001, 8'h80, 8'h80);
        wait_rsp();
        chk("post_rst_add", 32'(bus.rsp_result), 32'h0100);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
